pix_adj_ctrl: RTL and testbench
===============================

# pix_adj_ctrl

Front-panel adjustment controller for the pixel-filter chain. It debounces the raw up, down and select keys and tracks which filter is selected, cycling through `N_FILT` filters such as brightness and contrast. For the selected filter it issues single-cycle, frame-aligned `inc`/`dec` pulses, with auto-repeat while a key is held. It sits between the board keys and the `inc`/`dec` inputs of the per-pixel filters. Because each pulse lasts exactly one clock, every filter level changes by exactly one step per pulse.

## Interface
Parameters:
- `N_FILT`, 4: number of adjustable filters; must be ≥2.
- `DB_CYCLES`, 500000: consecutive stable cycles required before a debounced key changes; must be ≥2.
- `HOLD_FRAMES`, 30: frames from the first pulse to the first auto-repeat pulse; must be ≥1.
- `REPEAT_FRAMES`, 8: frames between auto-repeat pulses; must be ≥1.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_en`  in  1  one-cycle pulse per frame, synchronous to `clk`.
- `key_up`  in  1  raw key, active-high, asynchronous.
- `key_dn`  in  1  raw key, active-high, asynchronous.
- `key_sel`  in  1  raw key, active-high, asynchronous.
- `inc_out`  out  `N_FILT`  one-hot `inc` pulse; bit i drives filter i.
- `dec_out`  out  `N_FILT`  one-hot `dec` pulse; bit i drives filter i.
- `sel_idx`  out  `$clog2(N_FILT)`  currently selected filter.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Key conditioning.** Each key passes through a 2-flop synchronizer and then a debounce counter.
  - The debounced value flips only after the synchronized input has differed from it for `DB_CYCLES` consecutive cycles.
  - Any cycle of agreement clears the counter.
- **Select.** A rising edge of debounced `sel` advances `sel_idx` by one, wrapping from `N_FILT-1` to 0.
  - If the FSM is not in IDLE, the select edge also forces WAIT_REL and cancels any pending pulse.
- **FSM states.** IDLE, PEND, HOLD, RPT, WAIT_REL.
- **IDLE**
  - Exactly one of `up`/`dn` is high → latch `dir`, go to PEND.
  - Both high → WAIT_REL.
- **PEND**
  - On `frame_en` → emit one pulse in `dir` to `sel_idx`, clear `fcnt`, go to HOLD.
  - The pulse is emitted even if the key was released before `frame_en`, so a short tap always registers.
  - The opposite key pressing → WAIT_REL with no pulse.
- **HOLD**
  - `dir` key released → IDLE.
  - Each `frame_en` increments `fcnt`.
  - On the `frame_en` that brings `fcnt` to `HOLD_FRAMES` → pulse, clear `fcnt`, go to RPT.
- **RPT**
  - Same as HOLD, but the pulse fires every `REPEAT_FRAMES` frames.
  - Key released → IDLE.
- **Opposite key in HOLD/RPT.** The opposite key going high → WAIT_REL with no pulse.
- **WAIT_REL.** Stay until debounced `up` and `dn` are both low, then go to IDLE.
- **Priority when events coincide in one cycle** (highest first):
  1. Reset.
  2. Select edge.
  3. Release or opposite key.
  4. `frame_en` pulse.
  - So a release coinciding with a repeat `frame_en` produces no pulse.
- **Counters.** `fcnt` width is `$clog2(max(HOLD_FRAMES,REPEAT_FRAMES)+1)`; it never wraps.
- **Pulse targeting.** The selection is sampled in the same cycle as the pulse decision, so a pulse always targets the `sel_idx` value current at that moment.

## Timing
- **Reset values.** On `rst_n` low, asynchronously:
  - `inc_out = 0`, `dec_out = 0`, `sel_idx = 0`, `busy = 0`.
  - State = IDLE; all debounce and frame counters = 0; debounced keys = 0.
- **Key latency.** A raw key change reaches the debounced value after 2 + `DB_CYCLES` cycles.
- **Pulse latency.** Pulses are registered: asserted the cycle after the `frame_en` that triggers them, high for exactly 1 cycle.
- **Pulse exclusivity.** At most one bit across `inc_out | dec_out` is high in any cycle.
- **Busy.** `busy` is registered with the state.
- **Reset mid-operation.** Reset during PEND/HOLD/RPT drops any pulse that was due; no pulse is emitted after `rst_n` rises until a new press.

## Structure
- **Shared package `pix_ctrl_pkg`.** Holds the FSM state localparams (IDLE=0, PEND=1, HOLD=2, RPT=3, WAIT_REL=4, 3-bit) and the `dir` encoding (UP=0, DN=1). Later filter controllers reuse it.
- **Sub-module `key_debounce`.** Contains the synchronizer, debounce counter and registered rising-edge output.
  - Parameter `DB_CYCLES`.
  - Ports `clk`, `rst_n`, `raw`, `level`, `rise`.
  - Instantiated three times.
- **Top level.** Holds the select register, the FSM, `fcnt` and the one-hot output decode.

## Test plan
All scenarios use `N_FILT`=3, `DB_CYCLES`=4, `HOLD_FRAMES`=3, `REPEAT_FRAMES`=2, with `frame_en` every 20 cycles.
- **Glitch rejection.** `key_up` high for 3 cycles, then low → no pulses, `busy` stays 0, `sel_idx` stays 0.
- **Short tap.** `key_up` held 10 cycles, released before the next `frame_en` → exactly one pulse, `inc_out`=3'b001 for 1 cycle, the cycle after that `frame_en`.
- **Auto-repeat.** `key_dn` held across 9 frames → `dec_out[0]` pulses after frames 1, 4, 6 and 8 only; after release → IDLE and `busy`=0.
- **Select wrap and routing.** Three `key_sel` taps → `sel_idx` goes 1, 2, 0; a further tap gives `sel_idx`=1; then `key_dn` tap → `dec_out`=3'b010.
- **Both keys.** `key_up` and `key_dn` pressed together for 5 frames → no pulses; WAIT_REL until both are released, then IDLE.
- **Reset mid-repeat.** `rst_n` driven low during RPT, one cycle before a due pulse → no pulse; after release, all outputs 0 and `sel_idx`=0 with the key still held; a new press is required.

Source files
------------

// File: rtl/pix_ctrl_pkg.sv
// Shared definitions for the front-panel filter adjustment controllers.
package pix_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PEND     = 3'd1,
    HOLD     = 3'd2,
    RPT      = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw key conditioning: 2-flop synchronizer, stability counter, registered rising edge.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          seen_low_q, seen_low_d;
  logic          s;

  assign s = sync_q[1];

  // A key held through reset never produces a rise; it must be seen low first.
  always_comb begin
    cnt_d      = '0;
    level_d    = level_q;
    rise_d     = 1'b0;
    seen_low_d = seen_low_q | (vld_q[1] & ~s);
    if (s != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = s;
        rise_d  = s & seen_low_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      vld_q      <= '0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], raw};
      vld_q      <= {vld_q[0], 1'b1};
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      seen_low_q <= seen_low_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/pix_adj_ctrl.sv
// Filter selection and frame-aligned inc/dec pulse generation with auto-repeat.
module pix_adj_ctrl
  import pix_ctrl_pkg::*;
#(
  parameter int unsigned N_FILT        = 4,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned HOLD_FRAMES   = 30,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_en,
  input  logic                      key_up,
  input  logic                      key_dn,
  input  logic                      key_sel,
  output logic [N_FILT-1:0]         inc_out,
  output logic [N_FILT-1:0]         dec_out,
  output logic [$clog2(N_FILT)-1:0] sel_idx,
  output logic                      busy
);

  localparam int unsigned SW = $clog2(N_FILT);
  localparam int unsigned FW = $clog2(max_u(HOLD_FRAMES, REPEAT_FRAMES) + 1);
  localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);
  localparam logic [FW-1:0] RPT_LAST  = FW'(REPEAT_FRAMES - 1);

  logic up_lvl, up_rise, dn_lvl, dn_rise, sel_lvl_unused, sel_rise;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .raw(key_up), .level(up_lvl), .rise(up_rise)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .raw(key_dn), .level(dn_lvl), .rise(dn_rise)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk(clk), .rst_n(rst_n), .raw(key_sel), .level(sel_lvl_unused), .rise(sel_rise)
  );

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [N_FILT-1:0] inc_q, inc_d, dec_q, dec_d, onehot;
  logic              busy_q;
  logic              fire, dir_lvl, opp_lvl;

  assign dir_lvl = (dir_q == UP) ? up_lvl : dn_lvl;
  assign opp_lvl = (dir_q == UP) ? dn_lvl : up_lvl;
  assign onehot  = {{(N_FILT-1){1'b0}}, 1'b1} << sel_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    fcnt_d  = fcnt_q;
    sel_d   = sel_q;
    fire    = 1'b0;
    if (sel_rise) sel_d = (sel_q == SW'(N_FILT - 1)) ? '0 : sel_q + 1'b1;
    if (sel_rise && state_q != IDLE) begin
      state_d = WAIT_REL;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (up_rise || dn_rise) begin
            if (up_lvl && dn_lvl) begin
              state_d = WAIT_REL;
            end else begin
              dir_d   = up_rise ? UP : DN;
              state_d = PEND;
            end
          end
        end
        PEND: begin
          if (opp_lvl) begin
            state_d = WAIT_REL;
          end else if (frame_en) begin
            fire    = 1'b1;
            fcnt_d  = '0;
            state_d = HOLD;
          end
        end
        HOLD, RPT: begin
          if (opp_lvl) begin
            state_d = WAIT_REL;
          end else if (!dir_lvl) begin
            state_d = IDLE;
          end else if (frame_en) begin
            if (fcnt_q == ((state_q == HOLD) ? HOLD_LAST : RPT_LAST)) begin
              fire    = 1'b1;
              fcnt_d  = '0;
              state_d = RPT;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        WAIT_REL: begin
          if (!up_lvl && !dn_lvl) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    inc_d = (fire && dir_q == UP) ? onehot : '0;
    dec_d = (fire && dir_q == DN) ? onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= UP;
      fcnt_q  <= '0;
      sel_q   <= '0;
      inc_q   <= '0;
      dec_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      fcnt_q  <= fcnt_d;
      sel_q   <= sel_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign inc_out = inc_q;
  assign dec_out = dec_q;
  assign sel_idx = sel_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pix_adj_ctrl.sv
// Scoreboard bench for pix_adj_ctrl: expected pulses queued at stimulus, checked on output.
module tb_pix_adj_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, frame_en, key_up, key_dn, key_sel;
  logic [2:0] inc_out, dec_out;
  logic [1:0] sel_idx;
  logic       busy;

  typedef struct {
    int unsigned at;
    logic [2:0]  inc;
    logic [2:0]  dec;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  logic [1:0]  exp_sel = 2'd0;

  pix_adj_ctrl #(
    .N_FILT(3), .DB_CYCLES(4), .HOLD_FRAMES(3), .REPEAT_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_en(frame_en),
    .key_up(key_up), .key_dn(key_dn), .key_sel(key_sel),
    .inc_out(inc_out), .dec_out(dec_out), .sel_idx(sel_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame_en is sampled on the edge that makes cyc a multiple of 20
  initial begin
    frame_en = 1'b0;
    forever begin
      @(negedge clk);
      frame_en = (cyc % 20 == 19);
    end
  end

  function automatic logic [2:0] oh(input logic [1:0] s);
    logic [2:0] one;
    one = 3'b001;
    return one << s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].at < cyc) begin
      total++; bad++;
      $display("FAIL missed_pulse: no pulse by cycle %0d, required at cycle %0d inc=%b dec=%b",
               cyc, sbq[0].at, sbq[0].inc, sbq[0].dec);
      void'(sbq.pop_front());
    end
    if ((inc_out | dec_out) !== 3'b000) begin
      total++;
      if ($countones(inc_out | dec_out) != 1) begin
        bad++;
        $display("FAIL exclusivity: cycle %0d inc=%b dec=%b, required one bit", cyc, inc_out, dec_out);
      end
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: cycle %0d inc=%b dec=%b, required none", cyc, inc_out, dec_out);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.at || inc_out !== e.inc || dec_out !== e.dec) begin
          bad++;
          $display("FAIL pulse: cycle %0d inc=%b dec=%b, required cycle %0d inc=%b dec=%b",
                   cyc, inc_out, dec_out, e.at, e.inc, e.dec);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    @(negedge clk);
    while (cyc % 20 != 0) @(negedge clk);
  endtask

  task automatic push(input int unsigned at, input logic [2:0] i, input logic [2:0] d);
    exp_t e;
    e.at = at; e.inc = i; e.dec = d;
    sbq.push_back(e);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: %0d pulses outstanding, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (inc_out !== 3'b000 || dec_out !== 3'b000 || sel_idx !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: inc=%b dec=%b sel=%0d busy=%b, required all 0", name, inc_out, dec_out, sel_idx, busy);
    end
  endtask

  task automatic test_reset();
    wait_cyc(3);
    check_idle_outputs("reset_asserted");
    rst_n = 1'b1;
    wait_cyc(3);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_glitch();
    align();
    key_up = 1'b1;
    wait_cyc(3);
    key_up = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wait_cyc(1);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL glitch_busy: cycle %0d busy=%b, required 0", cyc, busy);
      end
    end
    total++;
    if (sel_idx !== 2'd0) begin
      bad++;
      $display("FAIL glitch_sel: sel=%0d, required 0", sel_idx);
    end
  endtask

  task automatic test_short_tap();
    int unsigned f0;
    align();
    f0 = cyc;
    push(f0 + 20, 3'b001, 3'b000);
    key_up = 1'b1;
    wait_cyc(10);
    key_up = 1'b0;
    wait_cyc(30);
    check_drained("short_tap");
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL short_tap_busy: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_auto_repeat();
    int unsigned f0;
    align();
    f0 = cyc;
    push(f0 + 20,  3'b000, oh(exp_sel));
    push(f0 + 80,  3'b000, oh(exp_sel));
    push(f0 + 120, 3'b000, oh(exp_sel));
    push(f0 + 160, 3'b000, oh(exp_sel));
    key_dn = 1'b1;
    wait_cyc(100);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL repeat_busy_held: busy=%b, required 1", busy);
    end
    wait_cyc(81);
    key_dn = 1'b0;
    wait_cyc(14);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL repeat_busy_released: busy=%b, required 0", busy);
    end
    wait_cyc(30);
    check_drained("auto_repeat");
  endtask

  task automatic test_select();
    int unsigned f0;
    for (int t = 0; t < 4; t++) begin
      align();
      key_sel = 1'b1;
      wait_cyc(10);
      key_sel = 1'b0;
      wait_cyc(9);
      exp_sel = (exp_sel == 2'd2) ? 2'd0 : exp_sel + 2'd1;
      total++;
      if (sel_idx !== exp_sel) begin
        bad++;
        $display("FAIL select_tap%0d: sel=%0d, required %0d", t, sel_idx, exp_sel);
      end
    end
    align();
    f0 = cyc;
    push(f0 + 20, 3'b000, oh(exp_sel));
    key_dn = 1'b1;
    wait_cyc(10);
    key_dn = 1'b0;
    wait_cyc(30);
    check_drained("select_route");
  endtask

  task automatic test_both_keys();
    align();
    key_up = 1'b1;
    key_dn = 1'b1;
    wait_cyc(50);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL both_wait_rel: busy=%b, required 1", busy);
    end
    wait_cyc(50);
    key_up = 1'b0;
    wait_cyc(30);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL both_one_held: busy=%b, required 1", busy);
    end
    key_dn = 1'b0;
    wait_cyc(10);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL both_released: busy=%b, required 0", busy);
    end
    check_drained("both_keys");
  endtask

  task automatic test_reset_mid_repeat();
    int unsigned f0;
    align();
    f0 = cyc;
    push(f0 + 20,  3'b000, oh(exp_sel));
    push(f0 + 80,  3'b000, oh(exp_sel));
    push(f0 + 120, 3'b000, oh(exp_sel));
    key_dn = 1'b1;
    wait_cyc(159);
    rst_n = 1'b0;
    wait_cyc(1);
    check_idle_outputs("midrst_asserted");
    wait_cyc(2);
    rst_n = 1'b1;
    exp_sel = 2'd0;
    wait_cyc(1);
    check_idle_outputs("midrst_released");
    for (int i = 0; i < 4; i++) begin
      wait_cyc(20);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL midrst_held_busy: cycle %0d busy=%b, required 0", cyc, busy);
      end
    end
    key_dn = 1'b0;
    wait_cyc(20);
    align();
    f0 = cyc;
    push(f0 + 20, 3'b000, oh(exp_sel));
    key_dn = 1'b1;
    wait_cyc(10);
    key_dn = 1'b0;
    wait_cyc(30);
    check_drained("midrst_new_press");
  endtask

  initial begin
    rst_n   = 1'b0;
    key_up  = 1'b0;
    key_dn  = 1'b0;
    key_sel = 1'b0;
    test_reset();
    test_glitch();
    test_short_tap();
    test_auto_repeat();
    test_select();
    test_both_keys();
    test_reset_mid_repeat();
    wait_cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
